// File: rtl/color_freq_emulator.sv
// rtl/color_freq_emulator.sv - two-channel colour-sensor square-wave generator (optional EDGE_COUNT_EN rise counters)
module color_freq_emulator #(
    parameter int CNT_W    = 32,
    parameter int MIN_HALF = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] green_half,
    input  logic [CNT_W-1:0] clear_half,
    output logic [1:0]       sensor_freq,
    output logic             cfg_error
`ifdef EDGE_COUNT_EN
    ,
    output logic [15:0]      green_rises,
    output logic [15:0]      clear_rises
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} ch_state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN = CNT_W'(MIN_HALF);

    logic [CNT_W-1:0] half_in [2];
    logic [1:0]       pend_vec;
    logic             accept, illegal, load;

    assign half_in[0] = clear_half;
    assign half_in[1] = green_half;

    assign cfg_ready = ~|pend_vec;
    assign accept    = cfg_valid & cfg_ready;
    assign illegal   = ((green_half != '0) && (green_half < MIN)) ||
                       ((clear_half != '0) && (clear_half < MIN));
    assign load      = accept & ~illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_error <= 1'b0;
        else        cfg_error <= accept & illegal;
    end

`ifdef EDGE_COUNT_EN
    logic [15:0] rises [2];
    assign green_rises = rises[1];
    assign clear_rises = rises[0];
`endif

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shadow_q, next_act;
        logic             pend_q, pend_clr, out_q;
        logic             boundary;

        // IDLE and an expired LOW phase are both points where a new word may take effect.
        assign boundary = (state_q == S_IDLE) || ((state_q == S_LOW) && (cnt_q == '0));
        assign next_act = pend_q ? shadow_q : act_q;

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            act_d    = act_q;
            pend_clr = 1'b0;
            if (!enable) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (boundary) begin
                act_d    = next_act;
                pend_clr = pend_q;
                if (next_act != '0) begin
                    state_d = S_HIGH;
                    cnt_d   = next_act - ONE;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end else begin
                case (state_q)
                    S_HIGH: begin
                        if (cnt_q == '0) begin
                            state_d = S_LOW;
                            cnt_d   = act_q - ONE;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    default: cnt_d = cnt_q - ONE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                act_q    <= '0;
                shadow_q <= '0;
                pend_q   <= 1'b0;
                out_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                act_q   <= act_d;
                out_q   <= (state_d == S_HIGH);
                if (load) begin
                    shadow_q <= half_in[ch];
                    pend_q   <= 1'b1;
                end else if (pend_clr) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign sensor_freq[ch] = out_q;
        assign pend_vec[ch]    = pend_q;

`ifdef EDGE_COUNT_EN
        logic [15:0] rises_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                            rises_q <= '0;
            else if ((state_d == S_HIGH) && !out_q) rises_q <= rises_q + 16'd1;
        end
        assign rises[ch] = rises_q;
`endif
    end

endmodule

// File: tb/tb_color_freq_emulator.sv
// tb/tb_color_freq_emulator.sv - vector table, directed sequences and randomized model check for color_freq_emulator
module tb_color_freq_emulator;

    logic        clk = 1'b0;
    logic        rst_n, enable, cfg_valid;
    logic        cfg_ready, cfg_error;
    logic [31:0] green_half, clear_half;
    logic [1:0]  sensor_freq;
`ifdef EDGE_COUNT_EN
    logic [15:0] green_rises, clear_rises;
`endif

    color_freq_emulator #(.CNT_W(32), .MIN_HALF(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .green_half(green_half), .clear_half(clear_half),
        .sensor_freq(sensor_freq), .cfg_error(cfg_error)
`ifdef EDGE_COUNT_EN
        , .green_rises(green_rises), .clear_rises(clear_rises)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Waveform model: each running channel tracks its position inside the current period.
    longint m_act [2], m_shadow [2], m_pos [2];
    bit     m_run [2], m_pend [2], m_out [2];
    bit     m_err;
    int     m_rises [2];

    typedef struct {
        bit          en;
        bit          valid;
        logic [31:0] g;
        logic [31:0] c;
        logic [1:0]  sf;
        bit          rdy;
        bit          err;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_act[ch] = 0; m_shadow[ch] = 0; m_pos[ch] = 0;
            m_run[ch] = 0; m_pend[ch] = 0; m_out[ch] = 0; m_rises[ch] = 0;
        end
        m_err = 0;
    endtask

    task automatic apply_pending(input int ch);
        if (m_pend[ch]) begin
            m_act[ch]  = m_shadow[ch];
            m_pend[ch] = 0;
        end
    endtask

    task automatic model_edge();
        bit     acc, bad;
        longint h [2];
        h[0] = longint'(clear_half);
        h[1] = longint'(green_half);
        acc = cfg_valid && !(m_pend[0] || m_pend[1]);
        bad = (h[0] != 0 && h[0] < 2) || (h[1] != 0 && h[1] < 2);
        for (int ch = 0; ch < 2; ch++) begin
            bit was = m_out[ch];
            if (!enable) begin
                m_run[ch] = 0;
            end else if (!m_run[ch]) begin
                apply_pending(ch);
                if (m_act[ch] != 0) begin m_run[ch] = 1; m_pos[ch] = 0; end
            end else begin
                m_pos[ch]++;
                if (m_pos[ch] == 2 * m_act[ch]) begin
                    apply_pending(ch);
                    if (m_act[ch] == 0) m_run[ch] = 0;
                    else                m_pos[ch] = 0;
                end
            end
            m_out[ch] = m_run[ch] && (m_pos[ch] < m_act[ch]);
            if (m_out[ch] && !was) m_rises[ch] = (m_rises[ch] + 1) % 65536;
        end
        m_err = acc && bad;
        if (acc && !bad) begin
            m_shadow[0] = h[0]; m_shadow[1] = h[1];
            m_pend[0] = 1; m_pend[1] = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("sensor_freq", 64'(sensor_freq), 64'({m_out[1], m_out[0]}));
        check("cfg_ready", 64'(cfg_ready), 64'(!(m_pend[0] || m_pend[1])));
        check("cfg_error", 64'(cfg_error), 64'(m_err));
`ifdef EDGE_COUNT_EN
        check("green_rises", 64'(green_rises), 64'(m_rises[1]));
        check("clear_rises", 64'(clear_rises), 64'(m_rises[0]));
`endif
    endtask

    task automatic load(input logic [31:0] g, input logic [31:0] c);
        cfg_valid = 1; green_half = g; clear_half = c;
        tick();
        cfg_valid = 0;
    endtask

    // Waits out any current high phase, then measures the next complete one.
    task automatic measure_high(input int ch, input int exp_len, input string name);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 200 && sensor_freq[ch]; i++) tick();
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (sensor_freq[ch]) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL %s: no rising edge within bound", name);
        end else begin
            n = 1;
            for (int i = 0; i < 200 && sensor_freq[ch]; i++) begin
                tick();
                if (sensor_freq[ch]) n++;
            end
            check(name, 64'(n), 64'(exp_len));
        end
    endtask

    initial begin
        tbl[0]  = '{1, 1, 5, 3, 2'b00, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 2'b11, 1, 0};
        tbl[2]  = '{1, 0, 0, 0, 2'b11, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 2'b11, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 2'b10, 1, 0};
        tbl[5]  = '{1, 0, 0, 0, 2'b10, 1, 0};
        tbl[6]  = '{1, 0, 0, 0, 2'b00, 1, 0};
        tbl[7]  = '{1, 0, 0, 0, 2'b01, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 2'b01, 1, 0};
        tbl[9]  = '{1, 0, 0, 0, 2'b01, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 2'b00, 1, 0};
        tbl[11] = '{1, 0, 0, 0, 2'b10, 1, 0};
        tbl[12] = '{1, 0, 0, 0, 2'b10, 1, 0};
        tbl[13] = '{1, 1, 1, 3, 2'b11, 1, 1};
        tbl[14] = '{1, 0, 0, 0, 2'b11, 1, 0};

        rst_n = 0; enable = 1; cfg_valid = 0; green_half = 0; clear_half = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset sensor_freq", 64'(sensor_freq), 64'd0);
        check("reset cfg_ready", 64'(cfg_ready), 64'd1);
        check("reset cfg_error", 64'(cfg_error), 64'd0);
        rst_n = 1;

        for (int i = 0; i < 15; i++) begin
            enable = tbl[i].en; cfg_valid = tbl[i].valid;
            green_half = tbl[i].g; clear_half = tbl[i].c;
            tick();
            check($sformatf("vec%0d sensor_freq", i), 64'(sensor_freq), 64'(tbl[i].sf));
            check($sformatf("vec%0d cfg_ready", i), 64'(cfg_ready), 64'(tbl[i].rdy));
            check($sformatf("vec%0d cfg_error", i), 64'(cfg_error), 64'(tbl[i].err));
        end
        cfg_valid = 0;

        // Reconfigure mid-high: the new half-period appears only after the old period completes.
        load(8, 3);
        check("reconfig ready low", 64'(cfg_ready), 64'd0);
        measure_high(1, 8, "green high after reconfig");
        measure_high(1, 8, "green high steady");

        load(0, 4);
        repeat (30) tick();
        check("green parked low", 64'(sensor_freq[1]), 64'd0);

        load(5, 3);
        repeat (7) tick();
        enable = 0;
        tick();
        check("outputs low after enable drop", 64'(sensor_freq), 64'd0);
        repeat (19) tick();
        enable = 1;
        measure_high(1, 5, "green full high after enable");

        repeat (3) tick();
        #2 rst_n = 0;
        #1 check("async reset outputs", 64'(sensor_freq), 64'd0);
        check("async reset ready", 64'(cfg_ready), 64'd1);
`ifdef EDGE_COUNT_EN
        check("async reset rises", 64'({green_rises, clear_rises}), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 15) != 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            green_half = $urandom_range(0, 6);
            clear_half = $urandom_range(0, 6);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
